axi4_lite_read_slave: RTL and testbench

AXI4_LITE_READ_SLAVE -- requirements
Module: axi4_lite_read_slave

---
 rtl/axi4_lite_pkg.sv | 16 +
 rtl/axi4_lite_read_slave_if.sv | 26 ++
 rtl/axi4_lite_addr_decode.sv | 38 +++
 rtl/axi4_lite_read_slave.sv | 134 +++++++++++++
 tb/tb_axi4_lite_read_slave.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions used by both the read slave and the read master.
// Contents: response code enum and a helper that flags error responses.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    function automatic logic resp_is_error(input axi_resp_e resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi4_lite_read_slave_if.sv
// AXI4-Lite read channels (AR + R) bundled as one interface.
// Signals: araddr/arvalid/arready (address channel),
//          rdata/rresp/rvalid/rready (data channel).
// Modports: master drives AR and RREADY; slave drives ARREADY and the R payload.
interface axi4_lite_read_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_addr_decode.sv
// Combinational address check for the read slave.
// Ports:
//   addr     in   byte address to classify
//   resp     out  OKAY, SLVERR (misaligned) or DECERR (outside the memory window)
//   word_idx out  word index of addr relative to MEM_BASE
module axi4_lite_addr_decode
    import axi4_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 32'h0000_0000,
    parameter int                    MEM_WORDS  = 1024
) (
    input  logic [ADDR_WIDTH-1:0]        addr,
    output axi_resp_e                    resp,
    output logic [$clog2(MEM_WORDS)-1:0] word_idx
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH:0] WINDOW_BYTES = (ADDR_WIDTH+1)'(4 * MEM_WORDS);

    // One extra bit so neither the window end nor an address below the base
    // can wrap: addr < MEM_BASE leaves the offset at 2^ADDR_WIDTH or above,
    // which always exceeds the window size, so a single compare covers both ends.
    logic [ADDR_WIDTH:0] offset_ext;

    assign offset_ext = {1'b0, addr} - {1'b0, MEM_BASE};

    always_comb begin
        resp = RESP_OKAY;
        if (offset_ext >= WINDOW_BYTES) begin
            resp = RESP_DECERR;
        end else if (addr[1:0] != 2'b00) begin
            resp = RESP_SLVERR;
        end
    end

    assign word_idx = addr[IDX_W+1:2] - MEM_BASE[IDX_W+1:2];

endmodule

// File: rtl/axi4_lite_read_slave.sv
// AXI4-Lite read-only slave in front of a synchronous one-cycle-latency memory.
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   bus           AXI4-Lite read channels (slave modport)
//   mem_rd_en     one-cycle read strobe to the memory
//   mem_rd_addr   memory word index, valid while mem_rd_en is high
//   mem_rd_data   memory read data, valid the cycle after mem_rd_en
//   rd_err_count  saturating count of SLVERR/DECERR responses delivered
//
// state      | meaning
// ST_IDLE    | ARREADY high, waiting for an address
// ST_MEM_REQ | issue the single memory read strobe
// ST_MEM_CAP | capture memory data into the RDATA register
// ST_RESP    | RVALID high, hold response until RREADY
module axi4_lite_read_slave
    import axi4_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 32'h0000_0000,
    parameter int                    MEM_WORDS  = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    axi4_lite_read_slave_if.slave        bus,
    output logic                         mem_rd_en,
    output logic [$clog2(MEM_WORDS)-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]        mem_rd_data,
    output logic [7:0]                   rd_err_count
);
    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_REQ,
        ST_MEM_CAP,
        ST_RESP
    } state_e;

    state_e                state;
    state_e                state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] dec_addr;
    axi_resp_e             dec_resp;
    logic [IDX_W-1:0]      dec_idx;
    logic [DATA_WIDTH-1:0] rdata_q;
    axi_resp_e             rresp_q;
    logic                  arready;
    logic                  rvalid;
    logic                  ar_hs;
    logic                  r_hs;

    // Gated by rst so ARREADY stays low while reset is held and rises as
    // soon as it is released.
    assign arready = (state == ST_IDLE) && !rst;
    assign rvalid  = (state == ST_RESP);
    assign ar_hs   = bus.arvalid && arready;
    assign r_hs    = rvalid && bus.rready;

    assign bus.arready = arready;
    assign bus.rvalid  = rvalid;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    // A single decoder serves both jobs: in IDLE it classifies the live
    // address for the handshake, afterwards it produces the word index of
    // the latched address.
    assign dec_addr = (state == ST_IDLE) ? bus.araddr : addr_q;

    axi4_lite_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_BASE   (MEM_BASE),
        .MEM_WORDS  (MEM_WORDS)
    ) u_addr_decode (
        .addr     (dec_addr),
        .resp     (dec_resp),
        .word_idx (dec_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (ar_hs) begin
                    state_next = (dec_resp == RESP_OKAY) ? ST_MEM_REQ : ST_RESP;
                end
            end
            ST_MEM_REQ: state_next = ST_MEM_CAP;
            ST_MEM_CAP: state_next = ST_RESP;
            ST_RESP: begin
                if (r_hs) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign mem_rd_en   = (state == ST_MEM_REQ);
    assign mem_rd_addr = mem_rd_en ? dec_idx : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= '0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            rd_err_count <= 8'h00;
        end else begin
            if (ar_hs) begin
                addr_q <= bus.araddr;
                if (dec_resp != RESP_OKAY) begin
                    rdata_q <= '0;
                    rresp_q <= dec_resp;
                end
            end
            if (state == ST_MEM_CAP) begin
                rdata_q <= mem_rd_data;
                rresp_q <= RESP_OKAY;
            end
            if (r_hs && resp_is_error(rresp_q) && (rd_err_count != 8'hFF)) begin
                rd_err_count <= rd_err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_read_slave.sv
// Scoreboard bench for axi4_lite_read_slave: expected R beats are queued as
// reads are issued; a negedge monitor compares every presented beat.
module tb_axi4_lite_read_slave;
    logic        clk;
    logic        rst;
    logic        mem_rd_en;
    logic [9:0]  mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic [7:0]  rd_err_count;

    logic [31:0] mem [1024];
    int          rd_pulses;
    int          tests;
    int          fails;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t exp_q[$];

    axi4_lite_read_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4_lite_read_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_BASE   (32'h0000_0000),
        .MEM_WORDS  (1024)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .rd_err_count (rd_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem[mem_rd_addr];
            rd_pulses   <= rd_pulses + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a beat presented with RREADY high completes at the next edge,
    // so it is popped; with RREADY low it must match the head and stay put.
    always @(negedge clk) begin
        if (!rst && bus.rvalid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%0h, expected no response (t=%0t)",
                         bus.rdata, $time);
            end else begin
                check("r_data", bus.rdata, exp_q[0].data);
                check("r_resp", bus.rresp, exp_q[0].resp);
                if (bus.rready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic ar_issue(input logic [31:0] addr);
        bit accepted;
        accepted = 1'b0;
        @(posedge clk);
        #1;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.arready) begin
                accepted = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        bus.araddr  = '0;
        check("ar_accept", accepted, 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input int stall);
        int   pulses_before;
        exp_t e;
        e.data        = exp_data;
        e.resp        = exp_resp;
        bus.rready    = (stall == 0);
        pulses_before = rd_pulses;
        exp_q.push_back(e);
        ar_issue(addr);
        @(negedge clk);
        if (exp_resp == 2'b00) begin
            check("mem_rd_en_req", mem_rd_en, 1);
            check("mem_rd_addr", mem_rd_addr, addr[11:2]);
            check("rvalid_in_req", bus.rvalid, 0);
            @(negedge clk);
            check("mem_rd_en_cap", mem_rd_en, 0);
            check("rvalid_in_cap", bus.rvalid, 0);
            @(negedge clk);
        end
        check("rvalid_latency", bus.rvalid, 1);
        check("mem_rd_en_resp", mem_rd_en, 0);
        if (stall > 0) begin
            check("arready_busy", bus.arready, 0);
            repeat (stall - 1) begin
                @(negedge clk);
                check("arready_busy", bus.arready, 0);
                check("rvalid_held", bus.rvalid, 1);
            end
            @(posedge clk);
            #1;
            bus.rready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        check("arready_after_r", bus.arready, 1);
        check("rvalid_after_r", bus.rvalid, 0);
        check("mem_read_count", rd_pulses - pulses_before, (exp_resp == 2'b00) ? 1 : 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests       = 0;
        fails       = 0;
        rd_pulses   = 0;
        mem_rd_data = '0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'hA000_0000 | i;
        end
        mem[0]    = 32'h1234_5678;
        mem[5]    = 32'hDEAD_BEEF;
        mem[1023] = 32'hCAFE_F00D;

        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        rst         = 1'b1;

        #8;
        check("rst_arready", bus.arready, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_mem_rd_addr", mem_rd_addr, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_rresp", bus.rresp, 0);
        check("rst_err_count", rd_err_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arready_after_rst", bus.arready, 1);

        do_read(32'h0000_0014, 32'hDEAD_BEEF, 2'b00, 0);
        do_read(32'h0000_0014, 32'hDEAD_BEEF, 2'b00, 5);
        check("err_count_okay", rd_err_count, 0);

        do_read(32'h0000_1000, 32'h0, 2'b11, 0);
        check("err_count_decerr", rd_err_count, 1);
        do_read(32'h0000_0006, 32'h0, 2'b10, 0);
        check("err_count_slverr", rd_err_count, 2);
        do_read(32'hFFFF_FFFC, 32'h0, 2'b11, 2);
        check("err_count_top", rd_err_count, 3);
        do_read(32'h0000_0FFC, 32'hCAFE_F00D, 2'b00, 0);
        do_read(32'h0000_0000, 32'h1234_5678, 2'b00, 0);
        check("err_count_hold", rd_err_count, 3);

        // Reset while the memory data is being captured.
        ar_issue(32'h0000_0014);
        @(negedge clk);
        check("midrst_mem_rd_en", mem_rd_en, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_arready", bus.arready, 0);
        check("midrst_rvalid", bus.rvalid, 0);
        check("midrst_rdata", bus.rdata, 0);
        check("midrst_rresp", bus.rresp, 0);
        check("midrst_mem_rd_en", mem_rd_en, 0);
        check("midrst_mem_rd_addr", mem_rd_addr, 0);
        check("midrst_err_count", rd_err_count, 0);
        repeat (3) begin
            @(negedge clk);
            check("midrst_rvalid_held", bus.rvalid, 0);
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("postrst_rvalid", bus.rvalid, 0);
            check("postrst_arready", bus.arready, 1);
        end
        check("postrst_queue_empty", exp_q.size(), 0);
        do_read(32'h0000_0014, 32'hDEAD_BEEF, 2'b00, 0);

        for (int i = 0; i < 260; i++) begin
            do_read(32'h0000_1000 + (i * 16), 32'h0, 2'b11, 0);
            if (i >= 250) begin
                check("err_count_sat", rd_err_count, (i + 1 > 255) ? 255 : i + 1);
            end
        end
        check("err_count_final", rd_err_count, 8'hFF);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
